// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and the
// width of the assertion/release counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    IDLE    = 2'd2
  } seq_state_e;

  // Counter must reach the release offset of the last channel.
  function automatic int seq_cnt_width(int n_ch, int pulse_cycles, int stagger_cycles);
    return $clog2(pulse_cycles + (n_ch - 1) * stagger_cycles + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Retriggerable reset generator: minimum-width assertion followed by an
// index-ordered staggered release, re-armed by a req/ack trigger with a channel mask.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int STAGGER_CYCLES = 1,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_req,
  input  logic [N_CH-1:0]  ch_mask,
  output logic             trig_ack,
  output logic [N_CH-1:0]  rst_out,
  output logic             busy,
  output logic             all_released,
  output logic [CNT_W-1:0] trig_count
);

  localparam int CW = seq_cnt_width(N_CH, PULSE_CYCLES, STAGGER_CYCLES);

  if (N_CH < 1 || PULSE_CYCLES < 1) begin : g_param_check
    $error("reset_sequencer: N_CH and PULSE_CYCLES must both be at least 1");
  end

  // Handshake: trig_req is level-held by the requester; it is accepted only in
  // IDLE, and acceptance is signalled by a single-cycle trig_ack pulse.
  seq_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [N_CH-1:0]  rst_q, rst_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] count_q, count_d;
  int               last_idx;
  int               end_off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      mask_q  <= '1;
      rst_q   <= '1;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    rst_d    = rst_q;
    ack_d    = 1'b0;
    count_d  = count_q;
    cnt_nxt  = cnt_q + CW'(1);
    last_idx = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (mask_q[i]) last_idx = i;
    end
    // The sequence ends on the edge that releases the highest masked channel.
    end_off = PULSE_CYCLES + last_idx * STAGGER_CYCLES;

    case (state_q)
      ASSERT, RELEASE: begin
        cnt_d = cnt_nxt;
        for (int i = 0; i < N_CH; i++) begin
          if (mask_q[i] && int'(cnt_nxt) == PULSE_CYCLES + i * STAGGER_CYCLES) rst_d[i] = 1'b0;
        end
        if (int'(cnt_nxt) >= end_off) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (int'(cnt_nxt) >= PULSE_CYCLES) begin
          state_d = RELEASE;
        end
      end
      IDLE: begin
        if (trig_req) begin
          ack_d  = 1'b1;
          mask_d = ch_mask;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          // An empty mask is acknowledged and counted but starts no sequence.
          if (|ch_mask) begin
            rst_d   = rst_q | ch_mask;
            cnt_d   = '0;
            state_d = ASSERT;
          end
        end
      end
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  assign trig_ack     = ack_q;
  assign rst_out      = rst_q;
  assign trig_count   = count_q;
  assign busy         = (state_q != IDLE);
  assign all_released = ~|rst_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a cycle-by-cycle vector table for power-on,
// masked triggers and held requests, plus hand sequences for async abort and saturation.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig_req;
  logic [3:0] ch_mask;
  logic       trig_ack;
  logic [3:0] rst_out;
  logic       busy;
  logic       all_released;
  logic [7:0] trig_count;

  logic       reset2;
  logic       trig_req2;
  logic [3:0] ch_mask2;
  logic       trig_ack2;
  logic [3:0] rst_out2;
  logic       busy2;
  logic       all_released2;
  logic [1:0] trig_count2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst_n;
    logic       req;
    logic [3:0] mask;
    logic [3:0] e_rst;
    logic       e_ack;
    logic       e_busy;
    logic       e_all;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk(clk), .reset(reset), .trig_req(trig_req), .ch_mask(ch_mask),
    .trig_ack(trig_ack), .rst_out(rst_out), .busy(busy),
    .all_released(all_released), .trig_count(trig_count)
  );

  reset_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset2), .trig_req(trig_req2), .ch_mask(ch_mask2),
    .trig_ack(trig_ack2), .rst_out(rst_out2), .busy(busy2),
    .all_released(all_released2), .trig_count(trig_count2)
  );

  function automatic vec_t mk(logic r, logic q, logic [3:0] m, logic [3:0] er,
                              logic ea, logic eb, logic eall, logic [7:0] ec);
    vec_t v;
    v.rst_n = r; v.req = q; v.mask = m; v.e_rst = er;
    v.e_ack = ea; v.e_busy = eb; v.e_all = eall; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check_outs(input string nm, input logic [3:0] er, input logic ea,
                            input logic eb, input logic eall, input logic [7:0] ec);
    n_vec++;
    if (rst_out !== er || trig_ack !== ea || busy !== eb || all_released !== eall ||
        trig_count !== ec) begin
      n_err++;
      $display("FAIL %s: got rst_out=%b ack=%b busy=%b all_rel=%b count=%0d, want rst_out=%b ack=%b busy=%b all_rel=%b count=%0d",
               nm, rst_out, trig_ack, busy, all_released, trig_count, er, ea, eb, eall, ec);
    end
  endtask

  task automatic apply(input int i);
    @(negedge clk);
    reset    = vecs[i].rst_n;
    trig_req = vecs[i].req;
    ch_mask  = vecs[i].mask;
    @(posedge clk);
    #1;
    check_outs($sformatf("vec%0d", i), vecs[i].e_rst, vecs[i].e_ack, vecs[i].e_busy,
               vecs[i].e_all, vecs[i].e_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] po_rst [5];
    logic       po_busy [5];
    int         c;
    logic [1:0] exp_sat;

    reset = 1'b0; trig_req = 1'b0; ch_mask = 4'b0000;
    reset2 = 1'b0; trig_req2 = 1'b0; ch_mask2 = 4'b0000;

    // Power-on release
    vecs[0]  = mk(0, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 4'b0000, 4'b1111, 0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 4'b0000, 4'b1110, 0, 1, 0, 0);
    vecs[3]  = mk(1, 0, 4'b0000, 4'b1100, 0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 4'b0000, 4'b1000, 0, 1, 0, 0);
    vecs[5]  = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    // Masked trigger 0101: bit0 clears at A+2, bit2 at A+4
    vecs[7]  = mk(1, 1, 4'b0101, 4'b0101, 1, 1, 0, 1);
    vecs[8]  = mk(1, 0, 4'b0000, 4'b0101, 0, 1, 0, 1);
    vecs[9]  = mk(1, 0, 4'b0000, 4'b0100, 0, 1, 0, 1);
    vecs[10] = mk(1, 0, 4'b0000, 4'b0100, 0, 1, 0, 1);
    vecs[11] = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    // Empty-mask trigger
    vecs[12] = mk(1, 1, 4'b0000, 4'b0000, 1, 0, 1, 2);
    vecs[13] = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 2);
    // Request held through a busy sequence (after the async abort clears the count)
    vecs[14] = mk(1, 1, 4'b0011, 4'b0011, 1, 1, 0, 1);
    vecs[15] = mk(1, 1, 4'b0011, 4'b0011, 0, 1, 0, 1);
    vecs[16] = mk(1, 1, 4'b0011, 4'b0010, 0, 1, 0, 1);
    vecs[17] = mk(1, 1, 4'b0011, 4'b0000, 0, 0, 1, 1);
    vecs[18] = mk(1, 1, 4'b0011, 4'b0011, 1, 1, 0, 2);
    vecs[19] = mk(1, 0, 4'b0000, 4'b0011, 0, 1, 0, 2);
    vecs[20] = mk(1, 0, 4'b0000, 4'b0010, 0, 1, 0, 2);
    vecs[21] = mk(1, 0, 4'b0000, 4'b0000, 0, 0, 1, 2);

    po_rst[0] = 4'b1111; po_rst[1] = 4'b1110; po_rst[2] = 4'b1100;
    po_rst[3] = 4'b1000; po_rst[4] = 4'b0000;
    po_busy[0] = 1; po_busy[1] = 1; po_busy[2] = 1; po_busy[3] = 1; po_busy[4] = 0;

    repeat (2) @(posedge clk);
    for (int i = 0; i < 14; i++) apply(i);

    // Full-mask trigger, then async reset in the middle of RELEASE
    @(negedge clk);
    trig_req = 1'b1; ch_mask = 4'b1111;
    @(posedge clk); #1;
    check_outs("abort_accept", 4'b1111, 1, 1, 0, 3);
    @(negedge clk);
    trig_req = 1'b0; ch_mask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_outs("abort_mid_release", 4'b1100, 0, 1, 0, 3);
    #2;
    reset = 1'b0;
    #1;
    check_outs("abort_async", 4'b1111, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      check_outs($sformatf("repower_edge%0d", e + 1), po_rst[e], 0, po_busy[e], ~po_busy[e], 0);
    end

    for (int i = 14; i < NV; i++) apply(i);

    // Saturating counter on the CNT_W=2 instance
    n_vec++;
    if (trig_count2 !== 2'd0 || rst_out2 !== 4'b1111) begin
      n_err++;
      $display("FAIL sat_reset: got count=%0d rst_out=%b, want count=0 rst_out=1111", trig_count2, rst_out2);
    end
    @(negedge clk);
    reset2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (busy2 !== 1'b0) begin
      n_err++;
      $display("FAIL sat_poweron: got busy=%b, want busy=0", busy2);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_sat = (k > 3) ? 2'd3 : 2'(k);
      @(negedge clk);
      trig_req2 = 1'b1; ch_mask2 = 4'b0001;
      @(posedge clk); #1;
      n_vec++;
      if (trig_ack2 !== 1'b1 || trig_count2 !== exp_sat) begin
        n_err++;
        $display("FAIL sat_trig%0d: got ack=%b count=%0d, want ack=1 count=%0d", k, trig_ack2, trig_count2, exp_sat);
      end
      @(negedge clk);
      trig_req2 = 1'b0; ch_mask2 = 4'b0000;
      c = 0;
      while (busy2 && c < 8) begin
        @(posedge clk); #1;
        c++;
      end
      n_vec++;
      if (busy2 !== 1'b0 || rst_out2 !== 4'b0000) begin
        n_err++;
        $display("FAIL sat_done%0d: got busy=%b rst_out=%b, want busy=0 rst_out=0000", k, busy2, rst_out2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised, retriggerable reset generator that drives N_CH independent active-high reset outputs, one per DUT reset domain, with a guaranteed minimum assertion width and a staggered, index-ordered release. It sits between the bench or system reset and the DUT domains. It replaces a fixed single-pulse reset with a req/ack-triggered, channel-maskable re-reset and a saturating trigger counter. Synthesizable; also used as-is in the verification top.

## Interface
- N_CH, 4, number of reset channels (≥1)
- PULSE_CYCLES, 2, minimum assertion length in clk cycles (≥1)
- STAGGER_CYCLES, 1, release spacing between consecutive channels (0 = simultaneous release)
- CNT_W, 8, width of trig_count
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low
- trig_req  input  1  re-reset request, held until acknowledged
- ch_mask  input  N_CH  channels affected by a trigger; sampled with trig_req
- trig_ack  output  1  one-cycle acceptance pulse
- rst_out  output  N_CH  active-high resets to DUT domains
- busy  output  1  sequence in progress
- all_released  output  1  high when rst_out == 0
- trig_count  output  CNT_W  accepted triggers, saturating

## Operation
- Reset value of every output while reset is low: rst_out all ones, trig_ack 0, busy 1, all_released 0, trig_count 0. The FSM is held in ASSERT with the internal counter at 0 and the latched mask at all ones.
- FSM states: ASSERT, RELEASE, IDLE.
  - ASSERT: counts PULSE_CYCLES edges, then enters RELEASE.
  - RELEASE: channel i clears at its offset. After the highest-index masked channel clears, the FSM enters IDLE.
  - IDLE: waits for trig_req.
- Internal counter width: $clog2(PULSE_CYCLES + (N_CH-1)*STAGGER_CYCLES + 1). The counter runs across ASSERT and RELEASE.
- In IDLE, trig_req == 1 at a rising edge is accepted on that edge:
  - trig_ack goes high for exactly one cycle.
  - ch_mask is latched.
  - rst_out[i] is set for each masked i.
  - trig_count increments and saturates at 2^CNT_W-1.
  - FSM enters ASSERT.
- trig_req while busy is ignored: no ack, no count. The requester keeps it high until the FSM returns to IDLE.
- ch_mask == 0 on acceptance: ack and count as normal. No rst_out change, FSM stays IDLE, busy stays 0.
- Unmasked channels never change during a triggered sequence.
- busy = (state != IDLE). all_released = ~|rst_out.
- reset low at any time, including mid-sequence, aborts immediately to the reset values. The full power-on sequence then restarts with all channels, and trig_count is cleared.

## Timing
- Power-on: number the edges after reset rises as 1, 2, …. rst_out[i] clears on edge PULSE_CYCLES + i*STAGGER_CYCLES. busy falls on the edge that clears channel N_CH-1.
- Trigger accepted on edge A:
  - rst_out[i] (masked) is high from edge A.
  - rst_out[i] clears on edge A + PULSE_CYCLES + i*STAGGER_CYCLES.
  - busy clears on the edge that clears the highest masked index.
- The earliest next acceptance is one edge after busy falls.
- Minimum assertion of any channel: PULSE_CYCLES full cycles.
- All outputs are registered except all_released and busy, which are decoded from registered state with no input-to-output combinational path.

## Structure
- Shared package reset_seq_pkg: state enum (ASSERT, RELEASE, IDLE) and the counter-width function.
- Single module; no sub-module is natural at this size.
- Parameter legality (PULSE_CYCLES ≥ 1, N_CH ≥ 1) is checked with an elaboration-time assertion.

## Test plan
All scenarios use the default parameters.
1. Power-on: reset released before edge 1.
   - rst_out is 1110 after edge 2, 1100 after edge 3, 1000 after edge 4, 0000 after edge 5.
   - busy falls after edge 5 and all_released rises.
2. Trigger with ch_mask = 0101, accepted at edge A.
   - trig_ack is high for one cycle and rst_out = 0101.
   - bit0 clears at A+2 and bit2 at A+4; busy falls at A+4.
   - trig_count = 1.
3. trig_req held high through a busy sequence.
   - Exactly one ack per sequence.
   - A second ack occurs one edge after busy falls.
4. ch_mask = 0000 trigger.
   - Ack given and trig_count increments.
   - rst_out stays 0000 and busy stays 0.
5. Async reset asserted mid-RELEASE (rst_out = 1100, trig_count = 3).
   - Outputs immediately become rst_out 1111, trig_count 0, busy 1.
   - The power-on release then follows scenario 1.
6. With CNT_W = 2, run 5 accepted triggers: trig_count reads 1, 2, 3, 3, 3.
